// File: rtl/audio_pkg.sv
// Shared widths and types for the stereo sample FIFO and its bus interface.
package audio_pkg;

  localparam int AUD_BIT_DEPTH_DEF = 24;
  localparam int FIFO_WIDTH_DEF    = 6;
  localparam int UNDERRUN_CNT_W    = 16;

  typedef struct packed {
    logic [AUD_BIT_DEPTH_DEF-1:0] left;
    logic [AUD_BIT_DEPTH_DEF-1:0] right;
  } stereo_frame_t;

  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
    return (v == '1) ? v : v + UNDERRUN_CNT_W'(1);
  endfunction

endpackage

// File: rtl/audio_sample_fifo_if.sv
// Mixer/mux-facing bus of the stereo sample FIFO; master drives pushes and read strobes.
interface audio_sample_fifo_if
  import audio_pkg::*;
#(
  parameter int FIFO_WIDTH    = FIFO_WIDTH_DEF,
  parameter int AUD_BIT_DEPTH = AUD_BIT_DEPTH_DEF
) ();

  logic                      wr_en;
  logic [AUD_BIT_DEPTH-1:0]  lsample_in;
  logic [AUD_BIT_DEPTH-1:0]  rsample_in;
  logic                      l_read;
  logic                      r_read;
  logic                      flush;
  logic [AUD_BIT_DEPTH-1:0]  lsound_out;
  logic [AUD_BIT_DEPTH-1:0]  rsound_out;
  logic [FIFO_WIDTH:0]       level;
  logic                      empty;
  logic                      full;
  logic                      overflow;
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt;

  modport master (
    output wr_en, lsample_in, rsample_in, l_read, r_read, flush,
    input  lsound_out, rsound_out, level, empty, full, overflow, underrun_cnt
  );

  modport slave (
    input  wr_en, lsample_in, rsample_in, l_read, r_read, flush,
    output lsound_out, rsound_out, level, empty, full, overflow, underrun_cnt
  );

endinterface

// File: rtl/sample_ram.sv
// Simple dual-port frame store: synchronous write, asynchronous (same-cycle) read.
// No reset on contents; readers must qualify data with their own occupancy state.
module sample_ram #(
  parameter int WIDTH  = 48,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_dat,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_dat
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/audio_sample_fifo.sv
// Show-ahead stereo frame FIFO: head frame visible the cycle after push/pop, r_read pops.
// Full push without a pop is dropped (sticky overflow); pop while empty bumps underrun_cnt.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int FIFO_WIDTH    = FIFO_WIDTH_DEF,
  parameter int AUD_BIT_DEPTH = AUD_BIT_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  audio_sample_fifo_if.slave bus
);

  localparam int DEPTH   = 2 ** FIFO_WIDTH;
  localparam int FRAME_W = 2 * AUD_BIT_DEPTH;

  typedef struct packed {
    logic [AUD_BIT_DEPTH-1:0] left;
    logic [AUD_BIT_DEPTH-1:0] right;
  } frame_t;

  localparam logic [FIFO_WIDTH:0] LEVEL_FULL = DEPTH[FIFO_WIDTH:0];

  logic [FIFO_WIDTH-1:0]     r_wr_ptr;
  logic [FIFO_WIDTH-1:0]     r_rd_ptr;
  logic [FIFO_WIDTH:0]       r_level;
  logic                      r_overflow;
  logic [UNDERRUN_CNT_W-1:0] r_underrun_cnt;

  logic   w_empty;
  logic   w_full;
  logic   w_pop_acc;
  logic   w_push_acc;
  logic   w_drop;
  logic   w_underrun;
  frame_t w_wr_frame;
  frame_t w_rd_frame;
  logic   w_unused_l_read;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LEVEL_FULL);

  // Flush swallows any push/pop of the same cycle, including their status side effects.
  assign w_pop_acc  = !bus.flush && bus.r_read && !w_empty;
  assign w_underrun = !bus.flush && bus.r_read && w_empty;
  assign w_push_acc = !bus.flush && bus.wr_en && (!w_full || w_pop_acc);
  assign w_drop     = !bus.flush && bus.wr_en && w_full && !w_pop_acc;

  // l_read only marks the left half of the mux read sequence; it never changes state.
  assign w_unused_l_read = bus.l_read;

  assign w_wr_frame.left  = bus.lsample_in;
  assign w_wr_frame.right = bus.rsample_in;

  sample_ram #(
    .WIDTH  (FRAME_W),
    .ADDR_W (FIFO_WIDTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  (w_wr_frame),
    .i_rd_addr (r_rd_ptr),
    .o_rd_dat  (w_rd_frame)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_overflow     <= 1'b0;
      r_underrun_cnt <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + FIFO_WIDTH'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + FIFO_WIDTH'(1);
      end
      if (w_push_acc && !w_pop_acc) begin
        r_level <= r_level + (FIFO_WIDTH + 1)'(1);
      end else if (!w_push_acc && w_pop_acc) begin
        r_level <= r_level - (FIFO_WIDTH + 1)'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_underrun) begin
        r_underrun_cnt <= sat_inc(r_underrun_cnt);
      end
    end
  end

  // Memory contents are stale when empty, so the head is forced to silence.
  assign bus.lsound_out   = w_empty ? '0 : w_rd_frame.left;
  assign bus.rsound_out   = w_empty ? '0 : w_rd_frame.right;
  assign bus.level        = r_level;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.overflow     = r_overflow;
  assign bus.underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: fixed vector table, directed corner sequences and random traffic vs a queue model.
module tb_audio_sample_fifo;
  import audio_pkg::*;

  localparam int FW    = FIFO_WIDTH_DEF;
  localparam int BD    = AUD_BIT_DEPTH_DEF;
  localparam int DEPTH = 1 << FW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  audio_sample_fifo_if #(.FIFO_WIDTH(FW), .AUD_BIT_DEPTH(BD)) bus ();

  audio_sample_fifo #(.FIFO_WIDTH(FW), .AUD_BIT_DEPTH(BD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [BD-1:0] l;
    logic [BD-1:0] r;
  } fr_t;

  fr_t mq[$];
  bit  m_ovf;
  int  m_uc;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_step(input bit rst, input bit wr, input bit rd, input bit fl, input fr_t f);
    bit popped;
    bit pushed;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_uc  = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      popped = rd && (mq.size() > 0);
      if (rd && mq.size() == 0 && m_uc < 65535) m_uc++;
      pushed = wr && (mq.size() < DEPTH || popped);
      if (wr && !pushed) m_ovf = 1'b1;
      if (popped) void'(mq.pop_front());
      if (pushed) mq.push_back(f);
    end
  endtask

  task automatic check_all(input string tag);
    logic [BD-1:0] el;
    logic [BD-1:0] er;
    el = '0;
    er = '0;
    if (mq.size() > 0) begin
      el = mq[0].l;
      er = mq[0].r;
    end
    chk({tag, "_lout"},  32'(bus.lsound_out),   32'(el));
    chk({tag, "_rout"},  32'(bus.rsound_out),   32'(er));
    chk({tag, "_level"}, 32'(bus.level),        32'(mq.size()));
    chk({tag, "_empty"}, 32'(bus.empty),        32'(mq.size() == 0));
    chk({tag, "_full"},  32'(bus.full),         32'(mq.size() == DEPTH));
    chk({tag, "_ovf"},   32'(bus.overflow),     32'(m_ovf));
    chk({tag, "_uc"},    32'(bus.underrun_cnt), 32'(m_uc));
  endtask

  task automatic cycle(input string tag, input bit rst, input bit wr, input bit lr, input bit rd,
                       input bit fl, input logic [BD-1:0] ls, input logic [BD-1:0] rs);
    fr_t f;
    f.l = ls;
    f.r = rs;
    reset          = rst;
    bus.wr_en      = wr;
    bus.l_read     = lr;
    bus.r_read     = rd;
    bus.flush      = fl;
    bus.lsample_in = ls;
    bus.rsample_in = rs;
    @(posedge clk);
    model_step(rst, wr, rd, fl, f);
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic logic [BD-1:0] rnd();
    return BD'($urandom);
  endfunction

  typedef struct {
    bit            rst, wr, lr, rd, fl;
    logic [BD-1:0] ls, rs;
    int            lvl;
    logic [BD-1:0] el, er;
    bit            ovf;
    int            uc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    fr_t  saved;
    logic [BD-1:0] a, b;

    //             rst wr lr rd fl  lsample     rsample    lvl  lout        rout       ovf uc
    tbl[0]  = '{1, 0, 0, 0, 0, 24'h000000, 24'h000000, 0, 24'h000000, 24'h000000, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 24'h000000, 24'h000000, 0, 24'h000000, 24'h000000, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 24'h123456, 24'hABCDEF, 1, 24'h123456, 24'hABCDEF, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 24'h000001, 24'hFFFFFF, 2, 24'h123456, 24'hABCDEF, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 24'h000000, 24'h000000, 2, 24'h123456, 24'hABCDEF, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 0, 24'h000000, 24'h000000, 1, 24'h000001, 24'hFFFFFF, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 0, 24'h000000, 24'h000000, 0, 24'h000000, 24'h000000, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0, 24'h000000, 24'h000000, 0, 24'h000000, 24'h000000, 0, 1};
    tbl[8]  = '{0, 0, 0, 1, 0, 24'h000000, 24'h000000, 0, 24'h000000, 24'h000000, 0, 2};
    tbl[9]  = '{0, 0, 0, 1, 0, 24'h000000, 24'h000000, 0, 24'h000000, 24'h000000, 0, 3};
    tbl[10] = '{0, 1, 0, 1, 0, 24'hAAAAAA, 24'h555555, 1, 24'hAAAAAA, 24'h555555, 0, 4};
    tbl[11] = '{0, 0, 0, 1, 0, 24'h000000, 24'h000000, 0, 24'h000000, 24'h000000, 0, 4};

    reset = 1'b1;
    bus.wr_en = 1'b0; bus.l_read = 1'b0; bus.r_read = 1'b0; bus.flush = 1'b0;
    bus.lsample_in = '0; bus.rsample_in = '0;

    for (int i = 0; i < 12; i++) begin
      cycle($sformatf("vec%0d", i), tbl[i].rst, tbl[i].wr, tbl[i].lr, tbl[i].rd, tbl[i].fl,
            tbl[i].ls, tbl[i].rs);
      chk($sformatf("tbl%0d_level", i), 32'(bus.level),        32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_lout", i),  32'(bus.lsound_out),   32'(tbl[i].el));
      chk($sformatf("tbl%0d_rout", i),  32'(bus.rsound_out),   32'(tbl[i].er));
      chk($sformatf("tbl%0d_ovf", i),   32'(bus.overflow),     32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_uc", i),    32'(bus.underrun_cnt), 32'(tbl[i].uc));
    end

    // Fill to full, simultaneous push/pop while full, then a dropped push.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 0, 1, 0, 0, 0, rnd(), rnd());
    chk("full_after_fill", 32'(bus.full), 32'd1);
    cycle("full_pushpop", 0, 1, 0, 1, 0, rnd(), rnd());
    chk("full_pushpop_level", 32'(bus.level), 32'(DEPTH));
    chk("full_pushpop_noovf", 32'(bus.overflow), 32'd0);
    saved.l = bus.lsound_out;
    saved.r = bus.rsound_out;
    cycle("overflow", 0, 1, 0, 0, 0, 24'h0F0F0F, 24'hF0F0F0);
    chk("overflow_set", 32'(bus.overflow), 32'd1);
    chk("overflow_level", 32'(bus.level), 32'(DEPTH));
    chk("overflow_head_l", 32'(bus.lsound_out), 32'(saved.l));
    chk("overflow_head_r", 32'(bus.rsound_out), 32'(saved.r));

    // Drain down to 10, then flush together with a push.
    for (int i = 0; i < DEPTH - 10; i++) cycle("drain", 0, 0, 1, 1, 0, '0, '0);
    chk("pre_flush_level", 32'(bus.level), 32'd10);
    cycle("flush", 0, 1, 0, 1, 1, rnd(), rnd());
    chk("flush_level", 32'(bus.level), 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_ovf_kept", 32'(bus.overflow), 32'd1);
    chk("flush_uc_kept", 32'(bus.underrun_cnt), 32'd4);

    // 200 frames in bursts of 5 so both pointers wrap several times.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 5; i++) cycle("wrap_push", 0, 1, 0, 0, 0, rnd(), rnd());
      for (int i = 0; i < 5; i++) begin
        cycle("wrap_lread", 0, 0, 1, 0, 0, '0, '0);
        cycle("wrap_pop", 0, 0, 0, 1, 0, '0, '0);
      end
    end

    // Random traffic, with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      a = rnd();
      b = rnd();
      cycle("rand", 0, ($urandom % 100) < 55, $urandom % 2 == 0, ($urandom % 100) < 45,
            ($urandom % 80) == 0, a, b);
    end

    // Reset mid-stream with concurrent traffic.
    for (int i = 0; i < 3; i++) cycle("pre_rst", 0, 1, 0, 0, 0, rnd(), rnd());
    cycle("rst_mid", 1, 1, 0, 1, 1, rnd(), rnd());
    chk("rst_mid_level", 32'(bus.level), 32'd0);
    chk("rst_mid_empty", 32'(bus.empty), 32'd1);
    chk("rst_mid_lout", 32'(bus.lsound_out), 32'd0);
    chk("rst_mid_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_mid_uc", 32'(bus.underrun_cnt), 32'd0);
    cycle("post_rst", 0, 1, 0, 0, 0, 24'h777777, 24'h888888);
    chk("post_rst_lout", 32'(bus.lsound_out), 32'h777777);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
